// File: rtl/tx_filt_pkg.sv
// Shared constants and types for the TX filter coefficient-table controller.
// Optional checksum feature is selected with TX_LUT_CKSUM_EN.
package tx_filt_pkg;

    localparam int COEF_W    = 18;
    localparam int NUM_TAPS  = 11;
    localparam int NUM_LVLS  = 8;
    localparam int LVL_W     = 3;
    localparam int TBL_DEPTH = NUM_LVLS * NUM_TAPS;
    localparam int CNT_W     = $clog2(TBL_DEPTH + 1);
    localparam int TAP_W     = $clog2(NUM_TAPS);
    localparam int CKSUM_W   = COEF_W + 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } cfg_state_t;

    // Sign-extend one coefficient word to checksum width.
    function automatic logic signed [CKSUM_W-1:0] sext_coef(input logic signed [COEF_W-1:0] w);
        return {{(CKSUM_W-COEF_W){w[COEF_W-1]}}, w};
    endfunction

endpackage

// File: rtl/tx_lut_bank.sv
// One coefficient bank: NUM_LVLS x NUM_TAPS registers, single write port,
// NUM_TAPS parallel combinational read ports (tap t reads its own column).
module tx_lut_bank
    import tx_filt_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [LVL_W-1:0]             wr_lvl,
    input  logic [TAP_W-1:0]             wr_tap,
    input  logic signed [COEF_W-1:0]     wr_data,
    input  logic [LVL_W*NUM_TAPS-1:0]    rd_lvl,
    output logic [COEF_W*NUM_TAPS-1:0]   rd_data
);

    logic [COEF_W-1:0] mem [NUM_LVLS][NUM_TAPS];

    // Table storage: cleared on reset, one entry written per accepted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_LVLS; l++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    mem[l][t] <= {COEF_W{1'b0}};
                end
            end
        end else if (we) begin
            mem[wr_lvl][wr_tap] <= wr_data;
        end
    end

    for (genvar t = 0; t < NUM_TAPS; t++) begin : g_rd
        assign rd_data[t*COEF_W +: COEF_W] = mem[rd_lvl[t*LVL_W +: LVL_W]][t];
    end

endmodule

// File: rtl/tx_filt_lut_cfg.sv
// Double-buffered coefficient LUT controller for the TX matched filter.
// Define TX_LUT_CKSUM_EN to add the cfg_cksum port and checksum-gated swap.
module tx_filt_lut_cfg
    import tx_filt_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    input  logic signed [COEF_W-1:0]     cfg_data,
`ifdef TX_LUT_CKSUM_EN
    input  logic signed [CKSUM_W-1:0]    cfg_cksum,
`endif
    output logic                         cfg_ready,
    input  logic                         sym_stb,
    input  logic [LVL_W*NUM_TAPS-1:0]    rd_lvl,
    output logic [COEF_W*NUM_TAPS-1:0]   rd_coef,
    output logic                         act_bank,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    cfg_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [LVL_W-1:0]    lvl_idx;
    logic [TAP_W-1:0]    tap_idx;
    logic                wr_en;
    logic                last_word;
    logic                cksum_ok;
    logic [COEF_W*NUM_TAPS-1:0] rd_bank0;
    logic [COEF_W*NUM_TAPS-1:0] rd_bank1;

    assign wr_en     = (state == LOAD) && cfg_valid && cfg_ready;
    assign last_word = wr_en && (cnt == CNT_W'(TBL_DEPTH - 1));

`ifdef TX_LUT_CKSUM_EN
    logic signed [CKSUM_W-1:0] cksum_sum;
    logic signed [CKSUM_W-1:0] sum_nxt;

    assign sum_nxt  = cksum_sum + sext_coef(cfg_data);
    assign cksum_ok = (sum_nxt == cfg_cksum);

    // Running sum of accepted words, restarted with each load.
    always_ff @(posedge clk) begin
        if (reset) begin
            cksum_sum <= {CKSUM_W{1'b0}};
        end else if ((state == IDLE) && cfg_start) begin
            cksum_sum <= {CKSUM_W{1'b0}};
        end else if (wr_en) begin
            cksum_sum <= sum_nxt;
        end
    end
`else
    assign cksum_ok = 1'b1;
`endif

    // Control FSM: load sequencing, bank select and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= {CNT_W{1'b0}};
            lvl_idx   <= {LVL_W{1'b0}};
            tap_idx   <= {TAP_W{1'b0}};
            act_bank  <= 1'b0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD;
                        cnt       <= {CNT_W{1'b0}};
                        lvl_idx   <= {LVL_W{1'b0}};
                        tap_idx   <= {TAP_W{1'b0}};
                        busy      <= 1'b1;
                        cfg_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        err <= 1'b1;
                    end
                    if (wr_en) begin
                        cnt <= cnt + CNT_W'(1);
                        if (tap_idx == TAP_W'(NUM_TAPS - 1)) begin
                            tap_idx <= {TAP_W{1'b0}};
                            lvl_idx <= lvl_idx + LVL_W'(1);
                        end else begin
                            tap_idx <= tap_idx + TAP_W'(1);
                        end
                        if (last_word) begin
                            cfg_ready <= 1'b0;
                            if (cksum_ok) begin
                                state <= WAIT_SWAP;
                            end else begin
                                // Bad checksum: shadow bank is abandoned, active bank untouched.
                                state <= IDLE;
                                busy  <= 1'b0;
                                err   <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_SWAP: begin
                    // A swap suppresses any simultaneous cfg_start error.
                    if (sym_stb) begin
                        act_bank <= ~act_bank;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (cfg_start) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    tx_lut_bank u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en & act_bank),
        .wr_lvl  (lvl_idx),
        .wr_tap  (tap_idx),
        .wr_data (cfg_data),
        .rd_lvl  (rd_lvl),
        .rd_data (rd_bank0)
    );

    tx_lut_bank u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en & ~act_bank),
        .wr_lvl  (lvl_idx),
        .wr_tap  (tap_idx),
        .wr_data (cfg_data),
        .rd_lvl  (rd_lvl),
        .rd_data (rd_bank1)
    );

    assign rd_coef = act_bank ? rd_bank1 : rd_bank0;

endmodule

// File: tb/tb_tx_filt_lut_cfg.sv
// Scoreboard bench for tx_filt_lut_cfg: expected done/err events are queued by
// the stimulus and matched by a monitor; table contents are checked directly.
module tb_tx_filt_lut_cfg;
    import tx_filt_pkg::*;

    logic clk = 1'b0;
    logic reset, cfg_start, cfg_valid, sym_stb;
    logic signed [COEF_W-1:0] cfg_data;
    logic cfg_ready, act_bank, busy, done, err;
    logic [LVL_W*NUM_TAPS-1:0]  rd_lvl;
    logic [COEF_W*NUM_TAPS-1:0] rd_coef;
`ifdef TX_LUT_CKSUM_EN
    logic signed [CKSUM_W-1:0] cfg_cksum;
`endif

    typedef struct { bit is_done; bit bank; } ev_t;
    ev_t exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tx_filt_lut_cfg dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data),
`ifdef TX_LUT_CKSUM_EN
        .cfg_cksum(cfg_cksum),
`endif
        .cfg_ready(cfg_ready), .sym_stb(sym_stb), .rd_lvl(rd_lvl), .rd_coef(rd_coef),
        .act_bank(act_bank), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int coef_at(input int t);
        logic [COEF_W-1:0] c;
        c = rd_coef[t*COEF_W +: COEF_W];
        return int'(c);
    endfunction

    task automatic set_lvl(input int l);
        logic [LVL_W-1:0] lv;
        lv = l[LVL_W-1:0];
        for (int t = 0; t < NUM_TAPS; t++) rd_lvl[t*LVL_W +: LVL_W] = lv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int word_val(input int mode, input int n);
        case (mode)
            0: return n + 1;
            1: return 1000 + n;
            2: return 2000 + n;
            default: return 100;
        endcase
    endfunction

    // Monitor: every done/err pulse must match the next queued expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset && (done || err)) begin
                n_checks++;
                if (done && err) begin
                    n_fail++;
                    $display("FAIL done_err_excl: done=1 err=1, required only one");
                end else if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: done=%0b err=%0b, required none", done, err);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done != done || e.bank != act_bank) begin
                        n_fail++;
                        $display("FAIL event: done=%0b bank=%0b, required done=%0b bank=%0b",
                                 done, act_bank, e.is_done, e.bank);
                    end
                end
            end
        end
    end

    task automatic push_ev(input bit is_done, input bit bank);
        ev_t e;
        e.is_done = is_done;
        e.bank    = bank;
        exp_q.push_back(e);
    endtask

    task automatic start_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // Stream words until stop_at accepted; optional 50% valid, mid-load cfg_start,
    // and an old-bank probe (tap0/tap10 of level 2) halfway through.
    task automatic stream(input int mode, input bit toggle, input int start_at,
                          input int stop_at, input int old0, input int old10, input int ck_delta);
        int n = 0;
        int guard = 0;
        bit sent = 1'b0;
        bit acc;
`ifdef TX_LUT_CKSUM_EN
        int s = 0;
        for (int i = 0; i < TBL_DEPTH; i++) s += word_val(mode, i);
        cfg_cksum = CKSUM_W'(s + ck_delta);
`endif
        while (n < stop_at && guard < 1000) begin
            cfg_valid = toggle ? guard[0] : 1'b1;
            cfg_data  = COEF_W'(word_val(mode, n));
            cfg_start = (n == start_at) && !sent;
            if (cfg_start) begin
                sent = 1'b1;
                push_ev(1'b0, act_bank);
            end
            if (old0 >= 0 && n == 44) begin
                chk("old_bank_tap0", coef_at(0), old0);
                chk("old_bank_tap10", coef_at(10), old10);
            end
            acc = cfg_valid && cfg_ready;
            tick();
            cfg_start = 1'b0;
            if (acc) n++;
            guard++;
        end
        cfg_valid = 1'b0;
        if (guard >= 1000) chk("stream_timeout", n, stop_at);
    endtask

    task automatic expect_drained(input string name);
        repeat (3) tick();
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; sym_stb = 1'b0;
        cfg_data = '0; rd_lvl = '0;
`ifdef TX_LUT_CKSUM_EN
        cfg_cksum = '0;
`endif
        repeat (2) tick();
        reset = 1'b0;

        // 1: reset state
        set_lvl(3);
        chk("rst_tap0", coef_at(0), 0);
        chk("rst_tap10", coef_at(10), 0);
        chk("rst_act_bank", int'(act_bank), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 0);
        chk("rst_busy", int'(busy), 0);
        cfg_valid = 1'b1; tick(); cfg_valid = 1'b0;   // ignored in IDLE
        chk("idle_valid_busy", int'(busy), 0);

        // 2: basic load and swap
        set_lvl(2);
        start_load();
        chk("load_ready", int'(cfg_ready), 1);
        chk("load_busy", int'(busy), 1);
        stream(0, 1'b0, -1, TBL_DEPTH, -1, 0, 0);
        chk("wait_ready", int'(cfg_ready), 0);
        chk("wait_bank", int'(act_bank), 0);
        chk("wait_tap0_old", coef_at(0), 0);
        push_ev(1'b1, 1'b1);
        sym_stb = 1'b1; tick(); sym_stb = 1'b0;
        chk("swap_bank", int'(act_bank), 1);
        chk("swap_busy", int'(busy), 0);
        expect_drained("swap_done_seen");
        chk("t2_lvl2_tap0", coef_at(0), 23);
        chk("t2_lvl2_tap10", coef_at(10), 33);
        set_lvl(0);
        chk("t2_lvl0_tap5", coef_at(5), 6);
        set_lvl(7);
        chk("t2_lvl7_tap10", coef_at(10), 88);

        // 3: sym_stb held high throughout the load
        set_lvl(2);
        sym_stb = 1'b1;
        tick();
        chk("idle_stb_bank", int'(act_bank), 1);
        start_load();
        stream(1, 1'b0, -1, TBL_DEPTH, 23, 33, 0);
        chk("last_word_no_swap", int'(act_bank), 1);
        chk("last_word_old", coef_at(0), 23);
        push_ev(1'b1, 1'b0);
        tick();
        sym_stb = 1'b0;
        chk("held_swap_bank", int'(act_bank), 0);
        expect_drained("held_done_seen");
        set_lvl(5);
        chk("t3_lvl5_tap0", coef_at(0), 1055);
        chk("t3_lvl5_tap10", coef_at(10), 1065);

        // 4: 50% valid, cfg_start at word 40
        start_load();
        stream(2, 1'b1, 40, TBL_DEPTH, -1, 0, 0);
        chk("t4_busy", int'(busy), 1);
        push_ev(1'b1, 1'b1);
        sym_stb = 1'b1; tick(); sym_stb = 1'b0;
        expect_drained("t4_events");
        for (int l = 0; l < NUM_LVLS; l++) begin
            set_lvl(l);
            for (int t = 0; t < NUM_TAPS; t++) chk("t4_word", coef_at(t), 2000 + l*NUM_TAPS + t);
        end

        // 5: reset mid-load at word 50
        start_load();
        stream(1, 1'b0, -1, 50, -1, 0, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        set_lvl(2);
        chk("t5_bank", int'(act_bank), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_ready", int'(cfg_ready), 0);
        chk("t5_tap0", coef_at(0), 0);
        chk("t5_tap10", coef_at(10), 0);
        sym_stb = 1'b1; tick(); sym_stb = 1'b0;
        chk("t5_no_swap", int'(act_bank), 0);

`ifdef TX_LUT_CKSUM_EN
        // 6: checksum match then mismatch
        start_load();
        stream(3, 1'b0, -1, TBL_DEPTH, -1, 0, 0);
        push_ev(1'b1, 1'b1);
        sym_stb = 1'b1; tick(); sym_stb = 1'b0;
        expect_drained("ck_ok_done");
        set_lvl(7);
        chk("ck_ok_val", coef_at(0), 100);
        start_load();
        push_ev(1'b0, 1'b1);
        stream(2, 1'b0, -1, TBL_DEPTH, -1, 0, 1);
        sym_stb = 1'b1; tick(); sym_stb = 1'b0;
        expect_drained("ck_bad_err");
        chk("ck_bad_bank", int'(act_bank), 1);
        chk("ck_bad_busy", int'(busy), 0);
        chk("ck_bad_val", coef_at(0), 100);
`endif

        expect_drained("final_queue");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
